// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: registered binary-to-one-hot decoder with valid/ready
// handshake on both sides. Out-of-range or unknown selects produce an all-zero
// result flagged by out_err.
// Optional feature macro: ONEHOT_DEC_VIOL_CNT_EN enables the saturating
// violation counter (viol_cnt/viol_clr); when undefined viol_cnt reads 0.
module onehot_decoder_pipe #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_err,
  input  logic               viol_clr,
  output logic [CNT_W-1:0]   viol_cnt
);

  if (SEL_W < 1) begin : g_bad_sel_w
    $error("onehot_decoder_pipe: SEL_W must be at least 1");
  end
  if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
    $error("onehot_decoder_pipe: NUM_OUT must lie in 2 .. 2**SEL_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("onehot_decoder_pipe: CNT_W must be at least 1");
  end

  // One extra bit so NUM_OUT == 2**SEL_W is representable as the limit.
  localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_OUT);

  logic               accept;
  logic               sel_unknown;
  logic               sel_legal;
  logic [NUM_OUT-1:0] dec;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Unknown-bit detection only exists in simulation; synthesis relies on the range check.
`ifndef SYNTHESIS
  assign sel_unknown = $isunknown(in_sel);
`else
  assign sel_unknown = 1'b0;
`endif

  // Decode the select; illegal selects yield an all-zero vector.
  always_comb begin
    sel_legal = ({1'b0, in_sel} < LIMIT) && !sel_unknown;
    dec       = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      dec[i] = sel_legal && (in_sel == SEL_W'(i));
    end
  end

  // Output register: load on accept, drop valid after a transfer, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_onehot <= dec;
      out_err    <= !sel_legal;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ONEHOT_DEC_VIOL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of accepted illegal selects; clear takes priority.
  always_ff @(posedge clk) begin
    if (rst || viol_clr) begin
      cnt_q <= '0;
    end else if (accept && !sel_legal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign viol_cnt = cnt_q;
`else
  logic unused_viol_clr;
  assign unused_viol_clr = viol_clr;
  assign viol_cnt        = '0;
`endif

  a_onehot0 : assert property (@(posedge clk) disable iff (rst)
                               out_valid |-> $onehot0(out_onehot));

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe: two instances (default
// parameters, and SEL_W=3/NUM_OUT=5/CNT_W=2) checked against a behavioural
// model every cycle, plus a vector table and directed corner-case sequences.
module tb_onehot_decoder_pipe;

`ifdef ONEHOT_DEC_VIOL_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b0;
  logic viol_clr = 1'b0;

  logic       va = 1'b0, ra, ova, erra;
  logic [1:0] sel_a = '0;
  logic [3:0] oha;
  logic [7:0] cnta;

  logic       vb = 1'b0, rb, ovb, errb;
  logic [2:0] sel_b = '0;
  logic [4:0] ohb;
  logic [1:0] cntb;

  int checks = 0;
  int failures = 0;

  // model state
  bit a_v, a_err, b_v, b_err;
  int a_oh, a_cnt, b_oh, b_cnt;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.SEL_W(2), .NUM_OUT(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_sel(sel_a),
    .out_valid(ova), .out_ready(out_ready), .out_onehot(oha), .out_err(erra),
    .viol_clr(viol_clr), .viol_cnt(cnta)
  );

  onehot_decoder_pipe #(.SEL_W(3), .NUM_OUT(5), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_sel(sel_b),
    .out_valid(ovb), .out_ready(out_ready), .out_onehot(ohb), .out_err(errb),
    .viol_clr(viol_clr), .viol_cnt(cntb)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock, update the model from the spec rules, compare both DUTs.
  task automatic tick();
    bit acc_a, acc_b, ill_a, ill_b;
    acc_a = !rst && va && (!a_v || out_ready);
    acc_b = !rst && vb && (!b_v || out_ready);
    ill_a = $isunknown(sel_a) || (int'(sel_a) >= 4);
    ill_b = $isunknown(sel_b) || (int'(sel_b) >= 5);
    @(posedge clk);
    if (rst) begin
      a_v = 0; a_oh = 0; a_err = 0; a_cnt = 0;
      b_v = 0; b_oh = 0; b_err = 0; b_cnt = 0;
    end else begin
      if (acc_a) begin
        a_v = 1; a_err = ill_a; a_oh = ill_a ? 0 : (1 << int'(sel_a));
      end else if (out_ready) a_v = 0;
      if (acc_b) begin
        b_v = 1; b_err = ill_b; b_oh = ill_b ? 0 : (1 << int'(sel_b));
      end else if (out_ready) b_v = 0;
      if (CE != 0) begin
        if (viol_clr) begin
          a_cnt = 0; b_cnt = 0;
        end else begin
          if (acc_a && ill_a && a_cnt < MAX_A) a_cnt++;
          if (acc_b && ill_b && b_cnt < MAX_B) b_cnt++;
        end
      end
    end
    #1;
    chk("a_valid", 32'(ova), 32'(a_v));
    chk("a_onehot", 32'(oha), 32'(a_oh));
    chk("a_err", 32'(erra), 32'(a_err));
    chk("a_cnt", 32'(cnta), 32'(a_cnt));
    chk("a_in_ready", 32'(ra), 32'(!rst && (!a_v || out_ready)));
    chk("b_valid", 32'(ovb), 32'(b_v));
    chk("b_onehot", 32'(ohb), 32'(b_oh));
    chk("b_err", 32'(errb), 32'(b_err));
    chk("b_cnt", 32'(cntb), 32'(b_cnt));
    chk("b_in_ready", 32'(rb), 32'(!rst && (!b_v || out_ready)));
  endtask

  typedef struct {
    bit         v;
    logic [1:0] sel;
    bit         rdy;
    bit         exp_v;
    logic [3:0] exp_oh;
    bit         exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [1:0] probe;
    bit four_state;

    tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 1'b0};
    tbl[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 4'b0100, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b0};

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(ova), 0);
    chk("rst_onehot", 32'(oha), 0);
    chk("rst_err", 32'(erra), 0);
    chk("rst_cnt", 32'(cnta), 0);
    chk("rst_in_ready", 32'(ra), 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", 32'(ra), 1);

    // back-to-back sweep
    for (int i = 0; i < 5; i++) begin
      va = tbl[i].v; sel_a = tbl[i].sel; out_ready = tbl[i].rdy;
      tick();
      chk("sweep_valid", 32'(ova), 32'(tbl[i].exp_v));
      chk("sweep_onehot", 32'(oha), 32'(tbl[i].exp_oh));
      chk("sweep_err", 32'(erra), 32'(tbl[i].exp_err));
      chk("sweep_cnt", 32'(cnta), 0);
    end
    va = 0;

    // range check on NUM_OUT=5
    vb = 1; sel_b = 3'd4; out_ready = 1;
    tick();
    chk("range4_onehot", 32'(ohb), 32'h10);
    chk("range4_err", 32'(errb), 0);
    for (int s = 5; s < 8; s++) begin
      sel_b = 3'(s);
      tick();
      chk("range_ill_onehot", 32'(ohb), 0);
      chk("range_ill_err", 32'(errb), 1);
    end
    chk("range_cnt", 32'(cntb), 32'(CE * 3));

    // saturation and clear on CNT_W=2
    vb = 0; viol_clr = 1;
    tick();
    chk("clr_cnt", 32'(cntb), 0);
    viol_clr = 0; vb = 1; sel_b = 3'd6;
    repeat (5) tick();
    chk("sat_cnt", 32'(cntb), 32'(CE * 3));
    viol_clr = 1;
    tick();
    chk("clr_wins_cnt", 32'(cntb), 0);
    chk("clr_wins_err", 32'(errb), 1);
    viol_clr = 0; vb = 0;
    tick();

    // back-pressure
    va = 1; sel_a = 2'd1; out_ready = 1;
    tick();
    chk("bp_first", 32'(oha), 32'h2);
    out_ready = 0; sel_a = 2'd3;
    repeat (3) begin
      tick();
      chk("bp_hold_onehot", 32'(oha), 32'h2);
      chk("bp_hold_valid", 32'(ova), 1);
      chk("bp_hold_in_ready", 32'(ra), 0);
    end
    out_ready = 1;
    #1;
    chk("bp_release_in_ready", 32'(ra), 1);
    tick();
    chk("bp_next_onehot", 32'(oha), 32'h8);
    chk("bp_next_valid", 32'(ova), 1);
    va = 0;
    tick();
    chk("bp_drain_valid", 32'(ova), 0);

    // unknown selects (only meaningful on a 4-state simulator)
    probe = 2'bx;
    four_state = $isunknown(probe);
    if (four_state) begin
      va = 1; sel_a = 2'b0x;
      tick();
      chk("x_onehot", 32'(oha), 0);
      chk("x_err", 32'(erra), 1);
      sel_a = 2'b1z;
      tick();
      chk("z_onehot", 32'(oha), 0);
      chk("z_err", 32'(erra), 1);
      chk("xz_cnt", 32'(cnta), 32'(CE * 2));
      va = 0; sel_a = 2'd0;
      tick();
    end

    // mid-stream reset with a stalled result and a nonzero count
    va = 1; sel_a = 2'd2; vb = 1; sel_b = 3'd7; out_ready = 1;
    tick();
    va = 0; vb = 0; out_ready = 0;
    tick();
    rst = 1;
    tick();
    chk("mrst_valid", 32'(ova), 0);
    chk("mrst_onehot", 32'(oha), 0);
    chk("mrst_cnt_b", 32'(cntb), 0);
    chk("mrst_in_ready", 32'(ra), 0);
    va = 1;
    tick();
    chk("mrst_in_ready_held", 32'(ra), 0);
    chk("mrst_no_accept", 32'(ova), 0);
    rst = 0; va = 0;
    #1;
    chk("mrst_release_in_ready", 32'(ra), 1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      va        = ($urandom_range(0, 3) != 0);
      vb        = ($urandom_range(0, 3) != 0);
      sel_a     = 2'($urandom);
      sel_b     = 3'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      viol_clr  = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Parametrised, registered binary-to-one-hot decoder with a valid/ready handshake on both sides and a saturating violation counter. It generalises the 2-to-4 unique-case decoder to any select width and output count. Out-of-range and unknown selects are flagged instead of silently holding the previous output. It sits between control logic producing an encoded select and downstream blocks that consume one-hot enables under back-pressure.

## Interface
- SEL_W, default 2: select width in bits, minimum 1.
- NUM_OUT, default 4: one-hot output count. Legal range 2 to 2**SEL_W; elaboration error outside it.
- CNT_W, default 8: violation counter width, minimum 1.

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream select is valid
- in_ready  output  1  block can accept a select this cycle
- in_sel  input  SEL_W  encoded select
- out_valid  output  1  out_onehot/out_err hold a valid result
- out_ready  input  1  downstream accepts the result this cycle
- out_onehot  output  NUM_OUT  decoded one-hot result
- out_err  output  1  result came from an illegal select
- viol_clr  input  1  synchronous clear of viol_cnt
- viol_cnt  output  CNT_W  saturating count of illegal selects accepted

## Operation
- Single output register stage: out_onehot, out_err, out_valid.
- in_ready = !rst && (!out_valid || out_ready). Combinational; no path from in_valid.
- Accept when in_valid && in_ready.
- Legal accept: in_sel < NUM_OUT and no X/Z bits.
  - out_onehot = 1 << in_sel
  - out_err = 0
  - out_valid = 1
- Illegal accept: in_sel >= NUM_OUT, or any X/Z bit in in_sel (simulation only; synthesis sees the range check alone).
  - out_onehot = 0, out_err = 1, out_valid = 1
  - viol_cnt increments
- No accept while out_valid && out_ready: out_valid goes to 0. out_onehot and out_err keep their last values; they are don't-care while out_valid = 0.
- Stall (out_valid && !out_ready): all outputs hold and in_ready = 0.
- out_onehot is zero or exactly one-hot whenever out_valid = 1.
- viol_cnt:
  - Saturates at 2**CNT_W - 1; never wraps.
  - viol_clr sets it to 0.
  - viol_clr and an illegal accept in the same cycle: the clear wins and the count becomes 0. That violation is not counted.
- Reset mid-operation: any pending result is discarded. No accept happens in a cycle with rst high.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle while out_ready = 1.
- Reset values:
  - out_valid 0, out_onehot 0, out_err 0, viol_cnt 0
  - in_ready is 0 while rst = 1 and 1 on the first cycle after rst falls.
- Handshake rules:
  - The result transfers on a cycle with out_valid && out_ready.
  - Once out_valid is 1, out_onehot and out_err hold until that transfer.
  - Upstream may change in_sel freely while in_ready = 0.
- viol_cnt updates on the same edge that loads the illegal result, so it is visible together with out_err.

## Configuration
- Macro: ONEHOT_DEC_VIOL_CNT_EN.
- Defined:
  - Violation counter implemented as described.
  - viol_clr is functional.
- Undefined:
  - No counter flops.
  - viol_cnt is tied to 0 and viol_clr is ignored.
  - out_err is still produced; the decode and handshake behaviour is identical.

## Test plan
- Sweep, default parameters, out_ready = 1: in_sel 0,1,2,3 on back-to-back cycles -> out_onehot 0001, 0010, 0100, 1000 one cycle later, out_valid continuously 1, out_err 0, viol_cnt 0.
- Range check, SEL_W = 3, NUM_OUT = 5: in_sel 4 -> out_onehot 10000. Then in_sel 5, 6, 7 -> out_onehot 00000, out_err 1, viol_cnt 3.
- Unknown select: in_sel 2'b0x, then 2'b1z -> both out_onehot 0000, out_err 1, viol_cnt 2. No X appears on any output.
- Back-pressure: hold out_ready = 0 for 3 cycles after in_sel 1 is accepted, with in_valid = 1 and in_sel 3 -> out_onehot stays 0010, in_ready stays 0. After out_ready rises: 0010 transfers, then 1000 one cycle later.
- Saturation and clear, CNT_W = 2: five illegal selects -> viol_cnt 3 (no wrap). viol_clr asserted in the same cycle as a sixth illegal select -> viol_cnt 0.
- Mid-stream reset: rst asserted while out_valid = 1 and out_ready = 0 -> next cycle out_valid 0, out_onehot 0, viol_cnt 0, in_ready 0 until rst falls. With the macro undefined, viol_cnt stays 0 throughout this and the previous scenario.
